// File: rtl/led_shift_driver_pkg.sv
// Shared constants, hold-time helper and frame FSM states for the MIDI LED driver.
// No logic, no latency, no backpressure.
package midi_pkg;

  localparam int PORTS_DEF = 16;
  localparam int CLOCK_HZ  = 12_000_000;

  function automatic int hold_cycles(input int clock, input int ms);
    return (clock / 1000) * ms;
  endfunction

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_LATCH
  } state_e;

endpackage

// File: rtl/led_shift_driver_if.sv
// Activity inputs and 74HC595 chain outputs of the LED driver.
// Pure wiring; the activity source cannot be stalled.
interface led_shift_driver_if #(
  parameter int PORTS = 16
);
  logic [PORTS-1:0] act_in;
  logic [PORTS-1:0] act_out;
  logic             sck;
  logic             rck;
  logic             ser;
  logic             frame_done;

  modport master (output act_in, act_out, input sck, rck, ser, frame_done);
  modport slave  (input act_in, act_out, output sck, rck, ser, frame_done);
endinterface

// File: rtl/led_shift_driver_stretch.sv
// Per-bit pulse stretcher: lit stays high for HOLD cycles after the last act cycle.
// Latency 1 cycle (act -> lit); always accepts, no backpressure.
module activity_stretch #(
  parameter int HOLD  = 600_000,
  parameter int PORTS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PORTS-1:0] act,
  output logic [PORTS-1:0] lit
);
  localparam int            CW     = $clog2(HOLD + 1);
  localparam logic [CW-1:0] HOLD_V = CW'(HOLD);

  logic [CW-1:0] cnt_q [PORTS];
  logic [CW-1:0] cnt_d [PORTS];

  // A reload takes priority even when the counter is about to hit zero.
  always_comb begin
    for (int i = 0; i < PORTS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (act[i]) begin
        cnt_d[i] = HOLD_V;
      end else if (cnt_q[i] != '0) begin
        cnt_d[i] = cnt_q[i] - CW'(1);
      end
      lit[i] = (cnt_q[i] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PORTS; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < PORTS; i++) cnt_q[i] <= cnt_d[i];
    end
  end
endmodule

// File: rtl/led_shift_driver.sv
// Stretches port activity and serialises it MSB-first into a 74HC595 chain, one frame per 1+(4*PORTS+1)*SCK_DIV cycles.
// Worst-case pulse-to-LED latency two frames; free-running, no backpressure.
module led_shift_driver
  import midi_pkg::*;
#(
  parameter int PORTS      = PORTS_DEF,
  parameter int CLOCK      = CLOCK_HZ,
  parameter int HOLD_MS    = 50,
  parameter int SCK_DIV    = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input logic               clk,
  input logic               rst_n,
  led_shift_driver_if.slave io
);
  localparam int HOLD = hold_cycles(CLOCK, HOLD_MS);
  localparam int NB   = 2 * PORTS;
  localparam int BW   = $clog2(NB);
  localparam int PW   = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(SCK_DIV - 1);

  logic [PORTS-1:0] lit_in;
  logic [PORTS-1:0] lit_out;

  activity_stretch #(.HOLD(HOLD), .PORTS(PORTS)) u_stretch_in (
    .clk(clk), .rst_n(rst_n), .act(io.act_in), .lit(lit_in)
  );
  activity_stretch #(.HOLD(HOLD), .PORTS(PORTS)) u_stretch_out (
    .clk(clk), .rst_n(rst_n), .act(io.act_out), .lit(lit_out)
  );

  state_e          state_q, state_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic [BW-1:0]   bitcnt_q, bitcnt_d;
  logic [NB-1:0]   shreg_q, shreg_d;
  logic            sck_q, sck_d;
  logic            rck_q, rck_d;
  logic            ser_q, ser_d;
  logic            frame_done_q, frame_done_d;
  logic            phase_last;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    bitcnt_d   = bitcnt_q;
    shreg_d    = shreg_q;
    ser_d      = ser_q;
    phase_last = (phase_q == PH_LAST);
    case (state_q)
      ST_LOAD: begin
        shreg_d  = {lit_out, lit_in};
        bitcnt_d = BW'(NB - 1);
        phase_d  = '0;
        state_d  = ST_SHIFT_LO;
        ser_d    = shreg_d[NB-1] ^ ACTIVE_LOW;
      end
      ST_SHIFT_LO: begin
        if (phase_last) begin
          phase_d = '0;
          state_d = ST_SHIFT_HI;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      ST_SHIFT_HI: begin
        if (phase_last) begin
          phase_d = '0;
          if (bitcnt_q == '0) begin
            state_d = ST_LATCH;
          end else begin
            // ser only moves on the falling sck edge, so it is stable for the whole high phase.
            shreg_d  = shreg_q << 1;
            bitcnt_d = bitcnt_q - BW'(1);
            state_d  = ST_SHIFT_LO;
            ser_d    = shreg_d[NB-1] ^ ACTIVE_LOW;
          end
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      ST_LATCH: begin
        if (phase_last) begin
          phase_d = '0;
          state_d = ST_LOAD;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      default: state_d = ST_LOAD;
    endcase
    sck_d        = (state_d == ST_SHIFT_HI);
    rck_d        = (state_d == ST_LATCH);
    frame_done_d = (state_d == ST_LATCH) && (phase_d == PH_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_LOAD;
      phase_q      <= '0;
      bitcnt_q     <= '0;
      shreg_q      <= '0;
      sck_q        <= 1'b0;
      rck_q        <= 1'b0;
      ser_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      bitcnt_q     <= bitcnt_d;
      shreg_q      <= shreg_d;
      sck_q        <= sck_d;
      rck_q        <= rck_d;
      ser_q        <= ser_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign io.sck        = sck_q;
  assign io.rck        = rck_q;
  assign io.ser        = ser_q;
  assign io.frame_done = frame_done_q;
endmodule
